uart_inst_loader: RTL and testbench



---
 rtl/uart_inst_loader.sv | 373 +++++++++++++++++++++++++++++++++++++
 tb/tb_uart_inst_loader.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_inst_loader.sv
// uart_inst_loader: UART (8N1) serial boot loader for the instruction memory.
// Receives a word count, then big-endian 32-bit words. It issues one write
// strobe per word and holds the core while a frame is being loaded.
// Optional build macro LOADER_CHKSUM_EN: a trailing XOR checksum byte is
// expected after the last word and is verified in the CHK state.
module uart_inst_loader #(
   parameter int CLKS_PER_BIT = 434,
   parameter int ADDR_W       = 8,
   parameter int TIMEOUT_CYC  = 50000000
) (
   input  logic              iCLK,
   input  logic              iRST_N,
   input  logic              iRXD,
   input  logic              iArm,
   output logic              oWrEn,
   output logic [ADDR_W-1:0] oWrAddr,
   output logic [31:0]       oWrData,
   output logic              oCpuHold,
   output logic              oBusy,
   output logic              oDone,
   output logic [1:0]        oErrCode
);

   localparam int BIT_W = $clog2(CLKS_PER_BIT + 1);
   localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
   localparam int CNT_W = ADDR_W + 1;
   localparam logic [BIT_W-1:0] HALF_M1 = BIT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0] FULL_M1 = BIT_W'(CLKS_PER_BIT - 1);
   localparam logic [TMO_W-1:0] TMO_M1  = TMO_W'(TIMEOUT_CYC - 1);

   // ---------------------------------------------------------------------
   // RX front end
   // ---------------------------------------------------------------------
   typedef enum logic [1:0] {RX_IDLE = 2'd0, RX_START = 2'd1, RX_DATA = 2'd2, RX_STOP = 2'd3} rx_state_t;

   logic             rxd_meta_q, rxd_sync_q, rxd_prev_q;
   rx_state_t        rx_state_q, rx_state_d;
   logic [BIT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             byte_valid_s, frame_err_s;
   logic [7:0]       rx_byte_s;

   // Bring the asynchronous RX line into the clock domain; keep one more stage for edge detection
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         rxd_meta_q <= 1'b1;
         rxd_sync_q <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         rxd_meta_q <= iRXD;
         rxd_sync_q <= rxd_meta_q;
         rxd_prev_q <= rxd_sync_q;
      end
   end

   // Deserializer state register
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= 3'd0;
         rx_shift_q <= 8'd0;
      end else begin
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
      end
   end

   // Deserializer next state: start-bit qualification, LSB-first data sampling, stop-bit sample
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      case (rx_state_q)
         RX_IDLE: begin
            if (rxd_prev_q && !rxd_sync_q) begin
               rx_state_d = RX_START;
               rx_cnt_d   = '0;
            end else begin
               rx_state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (rx_cnt_q == HALF_M1) begin
               rx_cnt_d = '0;
               rx_bit_d = 3'd0;
               if (!rxd_sync_q) begin
                  rx_state_d = RX_DATA;
               end else begin
                  rx_state_d = RX_IDLE;   // line high mid start bit: glitch
               end
            end else begin
               rx_cnt_d = rx_cnt_q + BIT_W'(1);
            end
         end
         RX_DATA: begin
            if (rx_cnt_q == FULL_M1) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) begin
                  rx_state_d = RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + 3'd1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + BIT_W'(1);
            end
         end
         RX_STOP: begin
            if (rx_cnt_q == FULL_M1) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
            end else begin
               rx_cnt_d = rx_cnt_q + BIT_W'(1);
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
            rx_cnt_d   = '0;
         end
      endcase
   end

   // Deserializer outputs: byte-valid or framing-error pulse in the stop-bit sample cycle
   always_comb begin
      rx_byte_s    = rx_shift_q;
      byte_valid_s = 1'b0;
      frame_err_s  = 1'b0;
      if ((rx_state_q == RX_STOP) && (rx_cnt_q == FULL_M1)) begin
         byte_valid_s = rxd_sync_q;
         frame_err_s  = !rxd_sync_q;
      end else begin
         byte_valid_s = 1'b0;
         frame_err_s  = 1'b0;
      end
   end

   // ---------------------------------------------------------------------
   // Loader FSM
   // ---------------------------------------------------------------------
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
`ifdef LOADER_CHKSUM_EN
      ST_CHK  = 3'd3,
`endif
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } st_t;

   st_t               state_q, state_d;
   logic [CNT_W-1:0]  n_q, n_d;
   logic [CNT_W-1:0]  widx_q, widx_d, widx_nxt_s;
   logic [1:0]        bidx_q, bidx_d;
   logic [31:0]       word_q, word_d, assembled_s;
   logic [TMO_W-1:0]  tmo_q, tmo_d;
   logic [1:0]        err_q, err_d;
   logic              wr_en_q, wr_en_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic              hold_q, hold_d, busy_q, busy_d, done_q, done_d;
`ifdef LOADER_CHKSUM_EN
   logic [7:0]        xor_q, xor_d;
`endif

   assign assembled_s = {word_q[23:0], rx_byte_s};
   assign widx_nxt_s  = widx_q + CNT_W'(1);

   // Loader state register plus word datapath and registered outputs
   always_ff @(posedge iCLK) begin
      if (!iRST_N) begin
         state_q   <= ST_IDLE;
         n_q       <= '0;
         widx_q    <= '0;
         bidx_q    <= 2'd0;
         word_q    <= 32'd0;
         tmo_q     <= '0;
         err_q     <= 2'b00;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= 32'd0;
         hold_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
`ifdef LOADER_CHKSUM_EN
         xor_q     <= 8'd0;
`endif
      end else begin
         state_q   <= state_d;
         n_q       <= n_d;
         widx_q    <= widx_d;
         bidx_q    <= bidx_d;
         word_q    <= word_d;
         tmo_q     <= tmo_d;
         err_q     <= err_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
`ifdef LOADER_CHKSUM_EN
         xor_q     <= xor_d;
`endif
      end
   end

   // Loader next state: abort on disarm, then framing error, then byte, then timeout
   always_comb begin
      state_d   = state_q;
      n_d       = n_q;
      widx_d    = widx_q;
      bidx_d    = bidx_q;
      word_d    = word_q;
      tmo_d     = tmo_q;
      err_d     = err_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
`ifdef LOADER_CHKSUM_EN
      xor_d     = xor_q;
`endif
      case (state_q)
         ST_IDLE: begin
            err_d = 2'b00;
            if (iArm) begin
               state_d = ST_HDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_HDR: begin
            if (!iArm) begin
               state_d = ST_IDLE;
            end else if (frame_err_s) begin
               state_d = ST_ERR;
               err_d   = 2'b01;
            end else if (byte_valid_s) begin
               state_d = ST_DATA;
               n_d     = (rx_byte_s == 8'd0) ? CNT_W'(256) : CNT_W'(rx_byte_s);
               widx_d  = '0;
               bidx_d  = 2'd0;
               tmo_d   = '0;
`ifdef LOADER_CHKSUM_EN
               xor_d   = rx_byte_s;
`endif
            end else begin
               state_d = ST_HDR;
            end
         end
         ST_DATA: begin
            if (!iArm) begin
               state_d = ST_IDLE;
            end else if (frame_err_s) begin
               state_d = ST_ERR;
               err_d   = 2'b01;
            end else if (byte_valid_s) begin
               word_d = assembled_s;
               tmo_d  = '0;
`ifdef LOADER_CHKSUM_EN
               xor_d  = xor_q ^ rx_byte_s;
`endif
               if (bidx_q == 2'd3) begin
                  wr_en_d   = 1'b1;
                  wr_addr_d = widx_q[ADDR_W-1:0];
                  wr_data_d = assembled_s;
                  widx_d    = widx_nxt_s;
                  bidx_d    = 2'd0;
                  if (widx_nxt_s == n_q) begin
`ifdef LOADER_CHKSUM_EN
                     state_d = ST_CHK;
`else
                     state_d = ST_DONE;
`endif
                  end else begin
                     state_d = ST_DATA;
                  end
               end else begin
                  bidx_d = bidx_q + 2'd1;
               end
            end else if (tmo_q == TMO_M1) begin
               state_d = ST_ERR;
               err_d   = 2'b10;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
`ifdef LOADER_CHKSUM_EN
         ST_CHK: begin
            if (!iArm) begin
               state_d = ST_IDLE;
            end else if (frame_err_s) begin
               state_d = ST_ERR;
               err_d   = 2'b01;
            end else if (byte_valid_s) begin
               if (rx_byte_s == xor_q) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 2'b11;
               end
            end else if (tmo_q == TMO_M1) begin
               state_d = ST_ERR;
               err_d   = 2'b10;
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end
`endif
         ST_DONE: begin
            if (!iArm) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_ERR: begin
            if (!iArm) begin
               state_d = ST_IDLE;
               err_d   = 2'b00;
            end else begin
               state_d = ST_ERR;
            end
         end
         default: begin
            state_d = ST_IDLE;
            err_d   = 2'b00;
         end
      endcase
   end

   // Loader output decode from the next state so flags register together with the state
   always_comb begin
      hold_d = 1'b0;
      busy_d = 1'b0;
      done_d = 1'b0;
      case (state_d)
         ST_HDR, ST_DATA: begin
            hold_d = 1'b1;
            busy_d = 1'b1;
         end
`ifdef LOADER_CHKSUM_EN
         ST_CHK: begin
            hold_d = 1'b1;
            busy_d = 1'b1;
         end
`endif
         ST_DONE: begin
            done_d = 1'b1;
         end
         ST_ERR: begin
            hold_d = 1'b1;
         end
         default: begin
            hold_d = 1'b0;
         end
      endcase
   end

   assign oWrEn    = wr_en_q;
   assign oWrAddr  = wr_addr_q;
   assign oWrData  = wr_data_q;
   assign oCpuHold = hold_q;
   assign oBusy    = busy_q;
   assign oDone    = done_q;
   assign oErrCode = err_q;

endmodule

// File: tb/tb_uart_inst_loader.sv
// Self-checking bench for uart_inst_loader. A frame-level model turns each
// byte list into the expected write sequence and final status; a compare
// process checks every write strobe and the hold of address/data between them.
module tb_uart_inst_loader;
   localparam int CPB = 8;
   localparam int AW  = 8;
   localparam int TMO = 200;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rxd = 1'b1;
   logic          arm = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [31:0]   wr_data;
   logic          hold, busy, done;
   logic [1:0]    err;

   always #5 clk = ~clk;

   uart_inst_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CYC(TMO)) dut (
      .iCLK(clk), .iRST_N(rst_n), .iRXD(rxd), .iArm(arm),
      .oWrEn(wr_en), .oWrAddr(wr_addr), .oWrData(wr_data),
      .oCpuHold(hold), .oBusy(busy), .oDone(done), .oErrCode(err)
   );

   int            n_tests = 0;
   int            n_fail = 0;
   logic [AW-1:0] exp_addr_q[$];
   logic [31:0]   exp_data_q[$];
   int            cap_n = 0;
   logic [AW-1:0] cap_addr[0:511];
   logic [31:0]   cap_data[0:511];
   logic [AW-1:0] last_addr = '0;
   logic [31:0]   last_data = 32'd0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Per-cycle compare of write strobes against the model queue
   always @(negedge clk) begin
      if (!rst_n) begin
         last_addr = '0;
         last_data = 32'd0;
      end else if (wr_en === 1'b1) begin
         n_tests++;
         if (exp_addr_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr, wr_data);
         end else begin
            logic [AW-1:0] ea;
            logic [31:0]   ed;
            ea = exp_addr_q.pop_front();
            ed = exp_data_q.pop_front();
            if (wr_addr !== ea || wr_data !== ed) begin
               n_fail++;
               $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h", wr_addr, wr_data, ea, ed);
            end
         end
         if (cap_n < 512) begin
            cap_addr[cap_n] = wr_addr;
            cap_data[cap_n] = wr_data;
         end
         cap_n++;
         last_addr = wr_addr;
         last_data = wr_data;
      end else begin
         if (wr_addr !== last_addr || wr_data !== last_data) begin
            n_tests++;
            n_fail++;
            $display("FAIL wr_hold: got %0h/%0h, expected %0h/%0h", wr_addr, wr_data, last_addr, last_data);
         end
         if (busy === 1'b1 && (hold !== 1'b1 || done !== 1'b0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL busy_flags: got hold %0b done %0b, expected 1 0", hold, done);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
      rxd = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         tick(CPB);
      end
      rxd = stop_bit;
      tick(CPB);
      rxd = 1'b1;
      tick(gap);
   endtask

   function automatic logic [7:0] xsum(input logic [7:0] f[$]);
      logic [7:0] x;
      x = 8'd0;
      foreach (f[i]) x = x ^ f[i];
      return x;
   endfunction

   // Frame model: N from header, whole words in order, status from completeness/checksum
   task automatic model_frame(input logic [7:0] f[$], output logic e_done, output logic [1:0] e_err);
      int n, avail, nw;
      n     = (f[0] == 8'd0) ? 256 : int'(f[0]);
      avail = (f.size() - 1) / 4;
      nw    = (avail < n) ? avail : n;
      for (int k = 0; k < nw; k++) begin
         exp_addr_q.push_back(AW'(k));
         exp_data_q.push_back({f[1+4*k], f[2+4*k], f[3+4*k], f[4+4*k]});
      end
      e_done = 1'b0;
      e_err  = 2'b00;
`ifdef LOADER_CHKSUM_EN
      if (f.size() >= 2 + 4 * n) begin
         logic [7:0] x;
         x = 8'd0;
         for (int i = 0; i < 1 + 4 * n; i++) x = x ^ f[i];
         if (x == f[1+4*n]) e_done = 1'b1;
         else e_err = 2'b11;
      end
`else
      if (avail >= n) e_done = 1'b1;
`endif
   endtask

   task automatic idle_flags(input string name);
      check({name, "_idle_hold"}, 32'(hold), 32'd0);
      check({name, "_idle_busy"}, 32'(busy), 32'd0);
      check({name, "_idle_done"}, 32'(done), 32'd0);
      check({name, "_idle_err"},  32'(err),  32'd0);
   endtask

   task automatic run_frame(input string name, input logic [7:0] f[$], input int maxgap);
      logic       e_done;
      logic [1:0] e_err;
      arm = 1'b1;
      tick(2);
      cap_n = 0;
      model_frame(f, e_done, e_err);
      foreach (f[i]) send_byte(f[i], 1'b1, $urandom_range(maxgap, 0));
      tick(12);
      check({name, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
      check({name, "_done"}, 32'(done), 32'(e_done));
      check({name, "_err"},  32'(err),  32'(e_err));
      check({name, "_hold"}, 32'(hold), 32'(e_err != 2'b00));
      check({name, "_busy"}, 32'(busy), 32'd0);
   endtask

   task automatic disarm(input string name);
      arm = 1'b0;
      tick(3);
      idle_flags(name);
   endtask

   function automatic void add_words(inout logic [7:0] f[$], input int nwords);
      for (int i = 0; i < 4 * nwords; i++) f.push_back(8'($urandom_range(255, 0)));
   endfunction

   initial begin
      logic [7:0] f[$];
      logic       e_done;
      logic [1:0] e_err;

      // Reset state
      tick(3);
      check("rst_wren", 32'(wr_en), 32'd0);
      check("rst_addr", 32'(wr_addr), 32'd0);
      check("rst_data", wr_data, 32'd0);
      idle_flags("rst");
      rst_n = 1'b1;
      tick(5);
      idle_flags("post_rst");

      // Two-word load with literal pins on the model
      arm = 1'b1;
      tick(2);
      check("hdr_busy", 32'(busy), 32'd1);
      check("hdr_hold", 32'(hold), 32'd1);
      f = '{8'h02, 8'h20, 8'h01, 8'h00, 8'h05, 8'h08, 8'h00, 8'h00, 8'h01};
`ifdef LOADER_CHKSUM_EN
      f.push_back(xsum(f));
`endif
      run_frame("two_words", f, 3);
      check("two_words_count", 32'(cap_n), 32'd2);
      check("two_words_a0", 32'(cap_addr[0]), 32'd0);
      check("two_words_d0", cap_data[0], 32'h20010005);
      check("two_words_a1", 32'(cap_addr[1]), 32'd1);
      check("two_words_d1", cap_data[1], 32'h08000001);
      check("two_words_done_lit", 32'(done), 32'd1);
      check("two_words_hold_lit", 32'(hold), 32'd0);
      disarm("two_words");

      // Random frames
      for (int r = 0; r < 2; r++) begin
         int n;
         n = $urandom_range(3, 1);
         f = '{8'(n)};
         add_words(f, n);
`ifdef LOADER_CHKSUM_EN
         f.push_back(xsum(f));
`endif
         run_frame("rand", f, 3);
         disarm("rand");
      end

`ifdef LOADER_CHKSUM_EN
      // Checksum pass and fail
      f = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01};
      run_frame("chk_pass", f, 2);
      check("chk_pass_done_lit", 32'(done), 32'd1);
      disarm("chk_pass");
      f = '{8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
      run_frame("chk_fail", f, 2);
      check("chk_fail_err_lit", 32'(err), 32'd3);
      check("chk_fail_hold_lit", 32'(hold), 32'd1);
      check("chk_fail_writes", 32'(cap_n), 32'd1);
      disarm("chk_fail");
`endif

      // Framing error inside a partial word
      arm = 1'b1;
      tick(2);
      cap_n = 0;
      f = '{8'h02};
      add_words(f, 1);
      model_frame(f, e_done, e_err);
      foreach (f[i]) send_byte(f[i], 1'b1, 2);
      send_byte(8'h3C, 1'b1, 2);
      send_byte(8'h5A, 1'b0, 4);
      tick(10);
      check("ferr_err", 32'(err), 32'd1);
      check("ferr_hold", 32'(hold), 32'd1);
      check("ferr_busy", 32'(busy), 32'd0);
      check("ferr_writes", 32'(cap_n), 32'd1);
      check("ferr_writes_left", 32'(exp_addr_q.size()), 32'd0);
      disarm("ferr");

      // Timeout after header and two data bytes
      arm = 1'b1;
      tick(2);
      cap_n = 0;
      send_byte(8'h01, 1'b1, 0);
      send_byte(8'h11, 1'b1, 0);
      send_byte(8'h22, 1'b1, 0);
      tick(150);
      check("tmo_early_busy", 32'(busy), 32'd1);
      check("tmo_early_err", 32'(err), 32'd0);
      tick(100);
      check("tmo_err", 32'(err), 32'd2);
      check("tmo_hold", 32'(hold), 32'd1);
      check("tmo_busy", 32'(busy), 32'd0);
      check("tmo_writes", 32'(cap_n), 32'd0);
      disarm("tmo");

      // Reset during word 1
      arm = 1'b1;
      tick(2);
      cap_n = 0;
      f = '{8'h02};
      add_words(f, 1);
      model_frame(f, e_done, e_err);
      foreach (f[i]) send_byte(f[i], 1'b1, 1);
      send_byte(8'h77, 1'b1, 1);
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      check("mrst_wren", 32'(wr_en), 32'd0);
      check("mrst_addr", 32'(wr_addr), 32'd0);
      check("mrst_data", wr_data, 32'd0);
      idle_flags("mrst");
      send_byte(8'h01, 1'b1, 1);
      send_byte(8'h02, 1'b1, 1);
      send_byte(8'h03, 1'b1, 1);
      tick(250);
      check("mrst_writes", 32'(cap_n), 32'd1);
      check("mrst_writes_left", 32'(exp_addr_q.size()), 32'd0);
      disarm("mrst");
      f = '{8'h01};
      add_words(f, 1);
`ifdef LOADER_CHKSUM_EN
      f.push_back(xsum(f));
`endif
      run_frame("mrst_fresh", f, 2);
      disarm("mrst_fresh");

      // Short low glitch in HDR is ignored
      arm = 1'b1;
      tick(2);
      rxd = 1'b0;
      tick(2);
      rxd = 1'b1;
      tick(20);
      check("glitch_busy", 32'(busy), 32'd1);
      check("glitch_err", 32'(err), 32'd0);
      f = '{8'h01};
      add_words(f, 1);
`ifdef LOADER_CHKSUM_EN
      f.push_back(xsum(f));
`endif
      run_frame("glitch", f, 2);
      disarm("glitch");

      // Header 0 means 256 words
      f = '{8'h00};
      add_words(f, 256);
`ifdef LOADER_CHKSUM_EN
      f.push_back(xsum(f));
`endif
      run_frame("n256", f, 0);
      check("n256_count", 32'(cap_n), 32'd256);
      check("n256_last_addr", 32'(cap_addr[255]), 32'h000000FF);
      check("n256_done_lit", 32'(done), 32'd1);
      disarm("n256");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
